// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC select encoding and priority decode.
// Pure combinational helpers; no state lives here.
package pc_pkg;

    localparam int PC_WIDTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BR     = 3'd1,
        SEL_JMP    = 3'd2,
        SEL_CALL   = 3'd3,
        SEL_RET    = 3'd4,
        SEL_RETERR = 3'd5,
        SEL_LOAD   = 3'd6
    } pcSel_e;

    // Highest-priority control wins; a return with nothing on the stack falls through sequentially.
    function automatic pcSel_e pcNextSel(
        input logic load,
        input logic ret,
        input logic rasEmpty,
        input logic call,
        input logic jump,
        input logic branchTaken
    );
        pcSel_e sel;
        if (load)
            sel = SEL_LOAD;
        else if (ret && !rasEmpty)
            sel = SEL_RET;
        else if (ret)
            sel = SEL_RETERR;
        else if (call)
            sel = SEL_CALL;
        else if (jump)
            sel = SEL_JMP;
        else if (branchTaken)
            sel = SEL_BR;
        else
            sel = SEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; push/pop take effect on the next Clk edge, TopData is combinational.
// No backpressure: a push when full overwrites the oldest entry, a pop when empty is dropped; both are flagged.
module pc_ras #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Push,
    input  logic             Pop,
    input  logic [WIDTH-1:0] PushData,
    output logic [WIDTH-1:0] TopData,
    output logic             Empty,
    output logic             Full,
    output logic             Overflow,
    output logic             Underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] stackMem [RAS_DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    topPtr;
    logic [CW-1:0]    count;
    logic             doPush;
    logic             doPop;

    // wrPtr is the next free slot; the pointer wraps so a full-stack push recycles the oldest slot.
    assign topPtr  = wrPtr - 1'b1;
    assign TopData = stackMem[topPtr];

    assign Empty = (count == '0);
    assign Full  = (count == DEPTH_C);

    assign doPop  = Pop && !Empty;
    assign doPush = Push && !Pop;

    assign Overflow  = doPush && Full;
    assign Underflow = Pop && Empty;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr <= '0;
            count <= '0;
        end else if (doPop) begin
            wrPtr <= wrPtr - 1'b1;
            count <= count - 1'b1;
        end else if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
            if (!Full)
                count <= count + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (doPush)
            stackMem[wrPtr] <= PushData;
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC select (load/ret/call/jump/branch/seq) and return-address stack; new PC one cycle after controls.
// Stall freezes PC, stack and error flag; no other backpressure.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEFAULT,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Stall,
    input  logic             Load,
    input  logic [WIDTH-1:0] PcInput,
    input  logic             Ret,
    input  logic             Call,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    output logic [WIDTH-1:0] PcOutput,
    output logic [WIDTH-1:0] PcPlusStep,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasErr
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pcSel_e           sel;
    logic [WIDTH-1:0] pcNext;
    logic [WIDTH-1:0] rasTop;
    logic             rasPush;
    logic             rasPop;
    logic             rasOverflow;
    logic             rasUnderflow;

    // Modulo-2^WIDTH add: the PC wraps from all-ones to zero silently.
    assign PcPlusStep = PcOutput + STEP_W;

    assign sel     = pcNextSel(Load, Ret, RasEmpty, Call, Jump, BranchTaken);
    assign rasPush = !Stall && (sel == SEL_CALL);
    assign rasPop  = !Stall && (sel == SEL_RET || sel == SEL_RETERR);

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) uRas (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Push      (rasPush),
        .Pop       (rasPop),
        .PushData  (PcPlusStep),
        .TopData   (rasTop),
        .Empty     (RasEmpty),
        .Full      (RasFull),
        .Overflow  (rasOverflow),
        .Underflow (rasUnderflow)
    );

    always_comb begin
        pcNext = PcPlusStep;
        unique case (sel)
            SEL_LOAD:   pcNext = PcInput;
            SEL_RET:    pcNext = rasTop;
            SEL_RETERR: pcNext = PcPlusStep;
            SEL_CALL:   pcNext = JumpTarget;
            SEL_JMP:    pcNext = JumpTarget;
            SEL_BR:     pcNext = BranchTarget;
            default:    pcNext = PcPlusStep;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            PcOutput <= RESET_VEC;
            RasErr   <= 1'b0;
        end else if (!Stall) begin
            PcOutput <= pcNext;
            if (rasOverflow || rasUnderflow)
                RasErr <= 1'b1;
        end
    end

endmodule
